// File: rtl/switch_led_ctrl_if.sv
// Board I/O bundle for switch_led_ctrl: raw switches in, LED drive and mode out.
// master = board/test side, slave = controller side.
interface switch_led_ctrl_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] P;
  logic [N_CH-1:0] Led;
  logic [1:0]      mode;

  modport master (output P, input Led, input mode);
  modport slave  (input P, output Led, output mode);
endinterface

// File: rtl/switch_led_ctrl.sv
// Switch-to-LED controller: synchronise (and optionally debounce) switches, drive LEDs in PASS/BLINK/CHASE.
// Optional per-channel debouncer built when SWITCH_LED_DEBOUNCE_EN is defined.
//
// state | meaning
// PASS  | LEDs mirror the filtered switches
// BLINK | end LEDs flash, HALF_PERIOD on / HALF_PERIOD off
// CHASE | one-hot light steps left every HALF_PERIOD cycles
module switch_led_ctrl #(
  parameter int N_CH        = 4,
  parameter int HALF_PERIOD = 25_000_000,
  parameter int DEB_CYCLES  = 1_000_000
) (
  input logic             clk,
  input logic             rst,
  switch_led_ctrl_if.slave io
);

  typedef enum logic [1:0] {
    PASS  = 2'b00,
    BLINK = 2'b01,
    CHASE = 2'b10
  } mode_t;

  localparam int              TW      = $clog2(HALF_PERIOD);
  localparam logic [TW-1:0]   TRELOAD = TW'(HALF_PERIOD - 1);
  localparam logic [N_CH-1:0] ONE     = N_CH'(1);
  localparam logic [N_CH-1:0] ENDS    = ONE | (ONE << (N_CH - 1));

  logic [N_CH-1:0] sync1, sync2, sw_db;
  mode_t           mode_q, mode_d;
  logic [TW-1:0]   tcnt, tcnt_d;
  logic            phase, phase_d;
  logic [N_CH-1:0] chase, chase_d;
  logic [N_CH-1:0] led_d;
  logic            chg, tick;

`ifdef SWITCH_LED_DEBOUNCE_EN
  localparam int            DW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DRELOAD = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] dcnt [N_CH];

  // Down-counter per channel; new value accepted after DEB_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_db <= '0;
      for (int i = 0; i < N_CH; i++) dcnt[i] <= DRELOAD;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sync2[i] == sw_db[i]) begin
          dcnt[i] <= DRELOAD;
        end else if (dcnt[i] == '0) begin
          sw_db[i] <= sync2[i];
          dcnt[i]  <= DRELOAD;
        end else begin
          dcnt[i] <= dcnt[i] - 1'b1;
        end
      end
    end
  end
`else
  assign sw_db = sync2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      mode_q <= PASS;
      tcnt   <= TRELOAD;
      phase  <= 1'b0;
      chase  <= ONE;
      io.Led <= '0;
    end else begin
      sync1  <= io.P;
      sync2  <= sync1;
      mode_q <= mode_d;
      tcnt   <= tcnt_d;
      phase  <= phase_d;
      chase  <= chase_d;
      io.Led <= led_d;
    end
  end

  // Timebase is a down-counter; terminal count zero marks the end of each half-period.
  always_comb begin
    mode_d = PASS;
    if (sw_db[0] & sw_db[N_CH-1]) mode_d = sw_db[1] ? CHASE : BLINK;

    chg     = (mode_d != mode_q);
    tick    = (tcnt == '0);
    tcnt_d  = tcnt - 1'b1;
    phase_d = phase;
    chase_d = chase;

    if (chg) begin
      tcnt_d  = TRELOAD;
      phase_d = 1'b0;
      chase_d = ONE;
    end else if (tick) begin
      tcnt_d  = TRELOAD;
      phase_d = ~phase;
      chase_d = {chase[N_CH-2:0], chase[N_CH-1]};
    end

    led_d = sw_db;
    case (mode_d)
      BLINK:   led_d = phase_d ? ENDS : '0;
      CHASE:   led_d = chase_d;
      default: led_d = sw_db;
    endcase
  end

  assign io.mode = mode_q;

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Self-checking bench for switch_led_ctrl: directed steps plus random switch patterns against a reference model.
module tb_switch_led_ctrl;
  localparam int N   = 4;
  localparam int HP  = 8;
  localparam int DEB = 4;
`ifdef SWITCH_LED_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
  localparam int LAT    = DEB;
`else
  localparam bit DEB_EN = 1'b0;
  localparam int LAT    = 0;
`endif
  localparam logic [N-1:0] ENDS_M = 4'b1001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  switch_led_ctrl_if #(.N_CH(N)) io ();

  switch_led_ctrl #(.N_CH(N), .HALF_PERIOD(HP), .DEB_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  // Reference model: sync chain as a delay line, debounce as "last DEB samples all disagree",
  // LED pattern from the number of edges elapsed since the mode was entered.
  logic [N-1:0] m_s1, m_s2, m_db;
  logic [N-1:0] exp_led;
  logic [1:0]   exp_mode;
  int           k_since;
  logic [N-1:0] win[$];

  function automatic logic [1:0] decode(input logic [N-1:0] v);
    if (!(v[0] && v[N-1])) return 2'b00;
    return v[1] ? 2'b10 : 2'b01;
  endfunction

  task automatic model_edge();
    logic [N-1:0] db_cur;
    logic [1:0]   dec;
    int           steps;
    bit           alldiff;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_db = '0;
      exp_led = '0; exp_mode = 2'b00; k_since = 0;
      win = {};
      repeat (DEB) win.push_back('0);
    end else begin
      db_cur = DEB_EN ? m_db : m_s2;
      dec    = decode(db_cur);
      if (dec != exp_mode) k_since = 0;
      else k_since++;
      exp_mode = dec;
      steps    = k_since / HP;
      case (dec)
        2'b01:   exp_led = (steps % 2 == 1) ? ENDS_M : '0;
        2'b10:   exp_led = N'(1) << (steps % N);
        default: exp_led = db_cur;
      endcase
      win.push_back(m_s2);
      if (win.size() > DEB) void'(win.pop_front());
      for (int ch = 0; ch < N; ch++) begin
        alldiff = 1'b1;
        foreach (win[j]) if (win[j][ch] == m_db[ch]) alldiff = 1'b0;
        if (alldiff) m_db[ch] = ~m_db[ch];
      end
      m_s2 = m_s1;
      m_s1 = io.P;
    end
  endtask

  task automatic check_outputs(input string tag);
    n_checks++;
    assert (io.Led === exp_led) else begin
      n_fail++;
      $error("FAIL %s led t=%0t observed=%b expected=%b", tag, $time, io.Led, exp_led);
    end
    n_checks++;
    assert (io.mode === exp_mode) else begin
      n_fail++;
      $error("FAIL %s mode t=%0t observed=%b expected=%b", tag, $time, io.mode, exp_mode);
    end
  endtask

  task automatic cyc(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs(tag);
    end
  endtask

  task automatic check_const(input string tag, input logic [N-1:0] led, input logic [1:0] md);
    n_checks++;
    assert (io.Led === led) else begin
      n_fail++;
      $error("FAIL %s led observed=%b expected=%b", tag, io.Led, led);
    end
    n_checks++;
    assert (io.mode === md) else begin
      n_fail++;
      $error("FAIL %s mode observed=%b expected=%b", tag, io.mode, md);
    end
  endtask

  initial begin
    io.P = 4'b1111;
    rst  = 1'b1;
    cyc(3, "reset");
    check_const("reset_hold", 4'b0000, 2'b00);

    rst = 1'b0;
    cyc(2 + LAT, "post_reset");
    check_const("post_reset_before", 4'b0000, 2'b00);
    cyc(1, "post_reset");
    check_const("post_reset_chase_entry", 4'b0001, 2'b10);

    io.P = 4'b0000;
    cyc(20, "idle");

    io.P = 4'b0101;
    cyc(2 + LAT, "pass_step");
    check_const("pass_before", 4'b0000, 2'b00);
    cyc(1, "pass_step");
    check_const("pass_0101", 4'b0101, 2'b00);
    cyc(5, "pass_hold");

    io.P = 4'b0001;
    cyc(3, "pulse_p2");
    io.P = 4'b0101;
    cyc(12, "pulse_after");
`ifdef SWITCH_LED_DEBOUNCE_EN
    check_const("pulse_filtered", 4'b0101, 2'b00);
`endif

    io.P = 4'b1001;
    cyc(3 + LAT, "blink_entry");
    check_const("blink_entry", 4'b0000, 2'b01);
    cyc(HP - 1, "blink_off");
    check_const("blink_off_end", 4'b0000, 2'b01);
    cyc(1, "blink_on");
    check_const("blink_on", 4'b1001, 2'b01);
    io.P = 4'b1101;
    cyc(5, "blink_p2");
    io.P = 4'b1001;
    cyc(3 * HP, "blink_run");

    io.P = 4'b1011;
    cyc(3 + LAT, "chase_entry");
    check_const("chase_entry", 4'b0001, 2'b10);
    cyc(HP, "chase_step1");
    check_const("chase_0010", 4'b0010, 2'b10);
    cyc(HP, "chase_step2");
    check_const("chase_0100", 4'b0100, 2'b10);
    cyc(HP, "chase_step3");
    check_const("chase_1000", 4'b1000, 2'b10);
    cyc(HP, "chase_wrap");
    check_const("chase_wrap", 4'b0001, 2'b10);

    // P[1] falls mid-chase at every tcnt phase so one change lands on a tick edge.
    for (int off = 0; off < HP; off++) begin
      io.P = 4'b1011;
      cyc(2 * HP + off, "chase_pre");
      io.P = 4'b1001;
      cyc(3 + LAT, "to_blink");
      check_const("to_blink_entry", 4'b0000, 2'b01);
      cyc(HP, "to_blink_on");
      check_const("to_blink_first_on", 4'b1001, 2'b01);
    end

    for (int r = 0; r < 250; r++) begin
      io.P = N'($urandom);
      cyc($urandom_range(1, 3 * HP), "random");
    end

    rst  = 1'b1;
    io.P = 4'b1011;
    cyc(2, "reset_mid");
    check_const("reset_mid", 4'b0000, 2'b00);
    rst = 1'b0;
    cyc(3 + LAT + 2 * HP, "restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
